// File: rtl/pipeline_hazard_controller.sv
// Hazard and redirect sequencer for the 5-stage ARMv8 pipeline.
// It handles load-use stalls, taken-branch flushes, the delayed BL link write and saturating debug counters.
module pipeline_hazard_controller #(
  parameter int ADDR_W = 64,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_br_taken,
  input  logic              ex_br_link,
  input  logic [ADDR_W-1:0] ex_br_target,
  input  logic [ADDR_W-1:0] ex_pc_plus4,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_redirect,
  output logic              lr_we,
  output logic [ADDR_W-1:0] lr_wdata,
  output logic [1:0]        ctrl_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  localparam logic [REG_W-1:0] XZR     = {REG_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic                lr_we_q, lr_we_d;
  logic [ADDR_W-1:0]   lr_wdata_q, lr_wdata_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic hz;
  logic br;
  logic take_br;
  logic take_hz;

  assign hz = ex_valid & ex_mem_read & (ex_rd != XZR) & id_valid &
              ((ex_rd == id_rn) | (ex_rd == id_rm));
  assign br = ex_valid & ex_br_taken;

  // Only a RUN cycle (or the unreachable encoding, which behaves as RUN) reacts to events;
  // the cycle after a stall or flush has a bubble in EX, so whatever it presents is ignored.
  always_comb begin
    state_d      = ST_RUN;
    take_br      = 1'b0;
    take_hz      = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pc_sel       = 1'b0;
    pc_redirect  = '0;
    case (state_q)
      ST_RUN, ST_ILLEGAL: begin
        if (br) begin
          take_br      = 1'b1;
          pc_sel       = 1'b1;
          pc_redirect  = ex_br_target;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = ST_FLUSH;
        end else if (hz) begin
          take_hz      = 1'b1;
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          state_d      = ST_STALL;
        end
      end
      ST_STALL: state_d = ST_RUN;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (reset) begin
      take_br      = 1'b0;
      take_hz      = 1'b0;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pc_sel       = 1'b0;
      pc_redirect  = '0;
      state_d      = ST_RUN;
    end
  end

  always_comb begin
    lr_we_d     = take_br & ex_br_link;
    lr_wdata_d  = lr_wdata_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (take_br & ex_br_link) lr_wdata_d = ex_pc_plus4;
    if (take_hz && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (take_br && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      lr_we_q     <= 1'b0;
      lr_wdata_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lr_we_q     <= lr_we_d;
      lr_wdata_q  <= lr_wdata_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign lr_we      = lr_we_q;
  assign lr_wdata   = lr_wdata_q;
  assign ctrl_state = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; counters built 4 bits wide so saturation is reachable.
module tb_pipeline_hazard_controller;

  localparam int ADDR_W = 64;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;

  logic              clock;
  logic              reset;
  logic              id_valid;
  logic [REG_W-1:0]  id_rn;
  logic [REG_W-1:0]  id_rm;
  logic              ex_valid;
  logic              ex_mem_read;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_br_taken;
  logic              ex_br_link;
  logic [ADDR_W-1:0] ex_br_target;
  logic [ADDR_W-1:0] ex_pc_plus4;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              pc_sel;
  logic [ADDR_W-1:0] pc_redirect;
  logic              lr_we;
  logic [ADDR_W-1:0] lr_wdata;
  logic [1:0]        ctrl_state;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int tests;
  int fails;

  pipeline_hazard_controller #(
    .ADDR_W(ADDR_W), .REG_W(REG_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_br_taken(ex_br_taken), .ex_br_link(ex_br_link),
    .ex_br_target(ex_br_target), .ex_pc_plus4(ex_pc_plus4),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pc_sel(pc_sel), .pc_redirect(pc_redirect),
    .lr_we(lr_we), .lr_wdata(lr_wdata), .ctrl_state(ctrl_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_rn = '0; id_rm = '0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    ex_br_taken = 1'b0; ex_br_link = 1'b0;
    ex_br_target = '0; ex_pc_plus4 = '0;
  endtask

  task automatic drive_load_use(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rn,
                                input logic [REG_W-1:0] rm, input logic idv);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd;
    id_valid = idv; id_rn = rn; id_rm = rm;
  endtask

  task automatic drive_branch(input logic [ADDR_W-1:0] tgt, input logic [ADDR_W-1:0] pc4,
                              input logic link);
    ex_valid = 1'b1; ex_br_taken = 1'b1; ex_br_link = link;
    ex_br_target = tgt; ex_pc_plus4 = pc4;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    #12;
    tests++; if (pc_write !== 1'b0) begin fails++; $display("FAIL rst_pc_write got=%0b exp=0", pc_write); end
    tests++; if (if_id_write !== 1'b0) begin fails++; $display("FAIL rst_if_id_write got=%0b exp=0", if_id_write); end
    tests++; if (ctrl_state !== 2'd0) begin fails++; $display("FAIL rst_state got=%0d exp=0", ctrl_state); end
    tests++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin fails++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    tests++; if (lr_we !== 1'b0 || lr_wdata !== 64'd0) begin fails++; $display("FAIL rst_lr got=%0b/%0h exp=0/0", lr_we, lr_wdata); end
    drive_branch(64'h40, 64'h8, 1'b0);
    #1;
    tests++; if (pc_sel !== 1'b0 || pc_redirect !== 64'd0 || if_id_flush !== 1'b0) begin fails++; $display("FAIL rst_redirect_masked got sel=%0b red=%0h fl=%0b exp=0/0/0", pc_sel, pc_redirect, if_id_flush); end
    drive_idle();
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin fails++; $display("FAIL run_default_enables got=%0b/%0b exp=1/1", pc_write, if_id_write); end
    step();
  endtask

  task automatic test_load_use();
    drive_load_use(5'd1, 5'd1, 5'd3, 1'b1);
    #1;
    tests++; if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin fails++; $display("FAIL lu_enables got=%0b/%0b exp=0/0", pc_write, if_id_write); end
    tests++; if (id_ex_bubble !== 1'b1 || if_id_flush !== 1'b0 || pc_sel !== 1'b0) begin fails++; $display("FAIL lu_bubble got b=%0b f=%0b s=%0b exp=1/0/0", id_ex_bubble, if_id_flush, pc_sel); end
    step();
    tests++; if (ctrl_state !== 2'd1) begin fails++; $display("FAIL lu_state got=%0d exp=1", ctrl_state); end
    tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    tests++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin fails++; $display("FAIL lu_stall_ignores_hz got pw=%0b b=%0b exp=1/0", pc_write, id_ex_bubble); end
    drive_idle();
    step();
    tests++; if (ctrl_state !== 2'd0 || stall_cnt !== 4'd1) begin fails++; $display("FAIL lu_back_to_run got st=%0d cnt=%0d exp=0/1", ctrl_state, stall_cnt); end
    // second source register match
    drive_load_use(5'd7, 5'd2, 5'd7, 1'b1);
    #1;
    tests++; if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1) begin fails++; $display("FAIL lu_rm got pw=%0b b=%0b exp=0/1", pc_write, id_ex_bubble); end
    step();
    drive_idle();
    step();
    tests++; if (stall_cnt !== 4'd2) begin fails++; $display("FAIL lu_rm_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_no_hazard();
    drive_load_use(5'd31, 5'd31, 5'd31, 1'b1);
    #1;
    tests++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin fails++; $display("FAIL nh_xzr got pw=%0b b=%0b exp=1/0", pc_write, id_ex_bubble); end
    step();
    tests++; if (ctrl_state !== 2'd0) begin fails++; $display("FAIL nh_xzr_state got=%0d exp=0", ctrl_state); end
    drive_load_use(5'd1, 5'd1, 5'd3, 1'b0);
    #1;
    tests++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin fails++; $display("FAIL nh_idinv got=%0b/%0b exp=1/1", pc_write, if_id_write); end
    ex_mem_read = 1'b0; id_valid = 1'b1;
    #1;
    tests++; if (pc_write !== 1'b1) begin fails++; $display("FAIL nh_not_load got=%0b exp=1", pc_write); end
    ex_mem_read = 1'b1; ex_valid = 1'b0;
    #1;
    tests++; if (pc_write !== 1'b1) begin fails++; $display("FAIL nh_exinv got=%0b exp=1", pc_write); end
    step();
    tests++; if (stall_cnt !== 4'd2) begin fails++; $display("FAIL nh_cnt got=%0d exp=2", stall_cnt); end
    drive_idle();
  endtask

  task automatic test_branch();
    drive_branch(64'h1C, 64'h8, 1'b0);
    #1;
    tests++; if (pc_sel !== 1'b1 || pc_redirect !== 64'h1C) begin fails++; $display("FAIL br_redirect got sel=%0b red=%0h exp=1/1c", pc_sel, pc_redirect); end
    tests++; if (if_id_flush !== 1'b1 || id_ex_bubble !== 1'b1 || pc_write !== 1'b1) begin fails++; $display("FAIL br_flush got f=%0b b=%0b pw=%0b exp=1/1/1", if_id_flush, id_ex_bubble, pc_write); end
    step();
    tests++; if (ctrl_state !== 2'd2 || flush_cnt !== 4'd1) begin fails++; $display("FAIL br_state got st=%0d cnt=%0d exp=2/1", ctrl_state, flush_cnt); end
    tests++; if (pc_sel !== 1'b0 || if_id_flush !== 1'b0 || lr_we !== 1'b0) begin fails++; $display("FAIL br_flush_ignores_br got sel=%0b f=%0b lr=%0b exp=0/0/0", pc_sel, if_id_flush, lr_we); end
    drive_idle();
    step();
    tests++; if (ctrl_state !== 2'd0 || flush_cnt !== 4'd1) begin fails++; $display("FAIL br_back_to_run got st=%0d cnt=%0d exp=0/1", ctrl_state, flush_cnt); end
  endtask

  task automatic test_bl();
    drive_branch(64'h2C, 64'h28, 1'b1);
    #1;
    tests++; if (pc_redirect !== 64'h2C || lr_we !== 1'b0) begin fails++; $display("FAIL bl_redirect got red=%0h lr=%0b exp=2c/0", pc_redirect, lr_we); end
    step();
    drive_idle();
    #1;
    tests++; if (lr_we !== 1'b1 || lr_wdata !== 64'h28) begin fails++; $display("FAIL bl_lr got we=%0b data=%0h exp=1/28", lr_we, lr_wdata); end
    step();
    tests++; if (lr_we !== 1'b0 || lr_wdata !== 64'h28) begin fails++; $display("FAIL bl_lr_drop got we=%0b data=%0h exp=0/28", lr_we, lr_wdata); end
    tests++; if (flush_cnt !== 4'd2 || ctrl_state !== 2'd0) begin fails++; $display("FAIL bl_cnt got cnt=%0d st=%0d exp=2/0", flush_cnt, ctrl_state); end
  endtask

  task automatic test_back_to_back();
    drive_branch(64'h100, 64'h50, 1'b0);
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_valid = 1'b1; id_rn = 5'd4; id_rm = 5'd0;
    #1;
    tests++; if (pc_write !== 1'b1 || if_id_write !== 1'b1 || pc_sel !== 1'b1 || pc_redirect !== 64'h100) begin fails++; $display("FAIL bh_priority got pw=%0b iw=%0b sel=%0b red=%0h exp=1/1/1/100", pc_write, if_id_write, pc_sel, pc_redirect); end
    step();
    tests++; if (ctrl_state !== 2'd2 || stall_cnt !== 4'd2 || flush_cnt !== 4'd3) begin fails++; $display("FAIL bh_counts got st=%0d sc=%0d fc=%0d exp=2/2/3", ctrl_state, stall_cnt, flush_cnt); end
    ex_br_taken = 1'b0;
    #1;
    tests++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin fails++; $display("FAIL bh_flush_ignores_hz got pw=%0b b=%0b exp=1/0", pc_write, id_ex_bubble); end
    step();
    tests++; if (ctrl_state !== 2'd0 || stall_cnt !== 4'd2) begin fails++; $display("FAIL bh_after got st=%0d sc=%0d exp=0/2", ctrl_state, stall_cnt); end
    // hazard still present in the following RUN cycle is taken
    #1;
    tests++; if (pc_write !== 1'b0) begin fails++; $display("FAIL bh_hz_next_run got pw=%0b exp=0", pc_write); end
    drive_idle();
    step();
  endtask

  task automatic test_reset_mid();
    drive_load_use(5'd2, 5'd2, 5'd0, 1'b1);
    step();
    tests++; if (ctrl_state !== 2'd1) begin fails++; $display("FAIL rm_in_stall got=%0d exp=1", ctrl_state); end
    #2 reset = 1'b1;
    #1;
    tests++; if (ctrl_state !== 2'd0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || pc_write !== 1'b0) begin fails++; $display("FAIL rm_stall_reset got st=%0d sc=%0d fc=%0d pw=%0b exp=0/0/0/0", ctrl_state, stall_cnt, flush_cnt, pc_write); end
    drive_idle();
    @(negedge clock);
    reset = 1'b0;
    drive_branch(64'h80, 64'h3C, 1'b1);
    step();
    drive_idle();
    #1;
    tests++; if (lr_we !== 1'b1) begin fails++; $display("FAIL rm_lr_pre got=%0b exp=1", lr_we); end
    #2 reset = 1'b1;
    #1;
    tests++; if (lr_we !== 1'b0 || lr_wdata !== 64'd0 || ctrl_state !== 2'd0 || flush_cnt !== 4'd0) begin fails++; $display("FAIL rm_lr_reset got we=%0b d=%0h st=%0d fc=%0d exp=0/0/0/0", lr_we, lr_wdata, ctrl_state, flush_cnt); end
    @(negedge clock);
    reset = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      drive_load_use(5'd9, 5'd0, 5'd9, 1'b1);
      step();
      drive_idle();
      step();
    end
    tests++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_stall got=%0d exp=15", stall_cnt); end
    for (int i = 0; i < 17; i++) begin
      drive_branch(64'h200 + 64'(i), 64'h4, 1'b0);
      step();
      drive_idle();
      step();
    end
    tests++; if (flush_cnt !== 4'd15 || stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_flush got fc=%0d sc=%0d exp=15/15", flush_cnt, stall_cnt); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_bl();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
